// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multicycle controller.
// Holds the opcode constants, the controller state encoding (which is also
// the value shown on the debug `state` port), the ALU operation codes and
// the select codes for the ALU B-input and PC-source multiplexers.
package mips_pkg;

    // Instruction opcodes, instruction register bits [31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Controller states; the numeric values are visible on the debug port
    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_REX    = 4'd7,
        S_RWB    = 4'd8,
        S_BEQ    = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JMP    = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    // ALU operation selects
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B-input selects
    localparam logic [1:0] ALU_B_REG     = 2'b00;
    localparam logic [1:0] ALU_B_FOUR    = 2'b01;
    localparam logic [1:0] ALU_B_IMM     = 2'b10;
    localparam logic [1:0] ALU_B_IMM_SH2 = 2'b11;

    // PC source selects
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: a Moore FSM that sequences FETCH, DECODE,
// EXECUTE, MEMORY and WRITEBACK for R-type, lw, sw, beq, j and (optionally)
// addi, traps on illegal opcodes and counts retired instructions.
//
// Parameters:
//   CNT_W         width of retired_cnt
//   MEM_HANDSHAKE 1: FETCH/MEMRD/MEMWR wait for mem_ready; 0: never wait
//   ADDI_EN       0: opcode 001000 traps as illegal
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   opcode          IR[31:26], sampled only in DECODE and MEMADR
//   zero            ALU zero flag; consumed by the datapath, not here
//   mem_ready       memory access completes this cycle
//   write_enable, write_memory, read_memory, branch, aluop,
//   pc_write, ir_write, iord, alu_src_a, alu_src_b, pc_src,
//   reg_dst, mem_to_reg   datapath controls (combinational from state)
//   state           current state encoding, for debug
//   illegal_op      sticky trap flag (high while in TRAP)
//   retired_cnt     completed-instruction counter, wraps
//
// Handshake: a memory access in FETCH, MEMRD or MEMWR completes in the cycle
// where "ready" (mem_ready, or always when MEM_HANDSHAKE=0) is high; until
// then the state and all outputs hold steady.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W         = 16,
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit ADDI_EN       = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             write_enable,
    output logic             write_memory,
    output logic             read_memory,
    output logic             branch,
    output logic [1:0]       aluop,
    output logic             pc_write,
    output logic             ir_write,
    output logic             iord,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired_cnt
);

    state_t cur_state;
    state_t next_state;
    logic   ready;
    logic   retire;

    // The zero flag goes straight to the datapath's PC-write gating together
    // with `branch`; the controller itself never looks at it.
    logic unused_zero;
    assign unused_zero = zero;

    assign ready = (MEM_HANDSHAKE == 1'b0) || mem_ready;
    assign state = cur_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_RST;
        end else begin
            cur_state <= next_state;
        end
    end

    always_comb begin
        next_state   = cur_state;
        write_enable = 1'b0;
        write_memory = 1'b0;
        read_memory  = 1'b0;
        branch       = 1'b0;
        aluop        = ALUOP_ADD;
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        iord         = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = ALU_B_REG;
        pc_src       = PC_SRC_ALU;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        illegal_op   = 1'b0;

        case (cur_state)
            S_RST: begin
                next_state = S_FETCH;
            end
            S_FETCH: begin
                read_memory = 1'b1;
                alu_src_b   = ALU_B_FOUR;
                aluop       = ALUOP_ADD;
                // IR load and PC+4 commit only once the fetch actually returns
                if (ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target precomputed here: PC + (imm << 2)
                alu_src_b = ALU_B_IMM_SH2;
                aluop     = ALUOP_ADD;
                case (opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_REX;
                    OP_BEQ:       next_state = S_BEQ;
                    OP_J:         next_state = S_JMP;
                    OP_ADDI:      next_state = ADDI_EN ? S_ADDIEX : S_TRAP;
                    default:      next_state = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = ALU_B_IMM;
                aluop      = ALUOP_ADD;
                // Only lw/sw reach here; anything but lw is treated as a store
                next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                read_memory = 1'b1;
                iord        = 1'b1;
                if (ready) next_state = S_MEMWB;
            end
            S_MEMWB: begin
                write_enable = 1'b1;
                mem_to_reg   = 1'b1;
                next_state   = S_FETCH;
            end
            S_MEMWR: begin
                write_memory = 1'b1;
                iord         = 1'b1;
                if (ready) next_state = S_FETCH;
            end
            S_REX: begin
                alu_src_a  = 1'b1;
                aluop      = ALUOP_FUNCT;
                next_state = S_RWB;
            end
            S_RWB: begin
                write_enable = 1'b1;
                reg_dst      = 1'b1;
                next_state   = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a  = 1'b1;
                aluop      = ALUOP_SUB;
                branch     = 1'b1;
                pc_src     = PC_SRC_ALUOUT;
                next_state = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = ALU_B_IMM;
                aluop      = ALUOP_ADD;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                write_enable = 1'b1;
                next_state   = S_FETCH;
            end
            S_JMP: begin
                pc_write   = 1'b1;
                pc_src     = PC_SRC_JUMP;
                next_state = S_FETCH;
            end
            S_TRAP: begin
                // Parked until reset; the flag is sticky because the state is
                illegal_op = 1'b1;
                next_state = S_TRAP;
            end
            default: begin
                next_state = S_RST;
            end
        endcase
    end

    // An instruction retires on the cycle that hands control back to FETCH.
    // RST->FETCH is not a retirement, nor is FETCH waiting on memory.
    assign retire = (next_state == S_FETCH) && (cur_state != S_FETCH) &&
                    (cur_state != S_RST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt <= '0;
        end else if (retire) begin
            retired_cnt <= retired_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl. Two instances share the stimulus:
// inst 0 uses defaults (CNT_W=16, handshake on, addi on), inst 1 uses
// CNT_W=4, handshake off, addi off. A per-instruction step-list model
// predicts state, outputs and retire count for both every cycle.
module tb_mips_multicycle_ctrl;

    localparam int W_A = 16;
    localparam int W_B = 4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    // ---------------- clock / reset / inputs ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       mem_ready;
    logic       zero;
    logic [5:0] opcode;

    // ---------------- DUT outputs ----------------
    logic a_we, a_wm, a_rm, a_br, a_pcw, a_irw, a_iord, a_sa, a_rd, a_mtr, a_ill;
    logic [1:0] a_aluop, a_sb, a_ps;
    logic [3:0] a_state;
    logic [W_A-1:0] a_cnt;
    logic b_we, b_wm, b_rm, b_br, b_pcw, b_irw, b_iord, b_sa, b_rd, b_mtr, b_ill;
    logic [1:0] b_aluop, b_sb, b_ps;
    logic [3:0] b_state;
    logic [W_B-1:0] b_cnt;

    logic [16:0] a_outs, b_outs;
    assign a_outs = {a_we, a_wm, a_rm, a_br, a_aluop, a_pcw, a_irw, a_iord,
                     a_sa, a_sb, a_ps, a_rd, a_mtr, a_ill};
    assign b_outs = {b_we, b_wm, b_rm, b_br, b_aluop, b_pcw, b_irw, b_iord,
                     b_sa, b_sb, b_ps, b_rd, b_mtr, b_ill};

    mips_multicycle_ctrl #(.CNT_W(W_A), .MEM_HANDSHAKE(1'b1), .ADDI_EN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .write_enable(a_we), .write_memory(a_wm), .read_memory(a_rm), .branch(a_br),
        .aluop(a_aluop), .pc_write(a_pcw), .ir_write(a_irw), .iord(a_iord),
        .alu_src_a(a_sa), .alu_src_b(a_sb), .pc_src(a_ps), .reg_dst(a_rd),
        .mem_to_reg(a_mtr), .state(a_state), .illegal_op(a_ill), .retired_cnt(a_cnt)
    );

    mips_multicycle_ctrl #(.CNT_W(W_B), .MEM_HANDSHAKE(1'b0), .ADDI_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .write_enable(b_we), .write_memory(b_wm), .read_memory(b_rm), .branch(b_br),
        .aluop(b_aluop), .pc_write(b_pcw), .ir_write(b_irw), .iord(b_iord),
        .alu_src_a(b_sa), .alu_src_b(b_sb), .pc_src(b_ps), .reg_dst(b_rd),
        .mem_to_reg(b_mtr), .state(b_state), .illegal_op(b_ill), .retired_cnt(b_cnt)
    );

    // ---------------- scoreboard ----------------
    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Each instance: current step, the step list of the instruction being
    // executed after DECODE, position in that list, retire count.
    bit hs[2]    = '{1'b1, 1'b0};
    bit aen[2]   = '{1'b1, 1'b0};
    int cw[2]    = '{W_A, W_B};
    int cur[2];
    int cnt[2];
    int steps[2][4];
    int nsteps[2];
    int pos[2];

    function automatic logic [16:0] exp_outs(input int s, input bit rdy);
        logic we, wm, rm, br, pcw, irw, iord, sa, rd, mtr, ill;
        logic [1:0] al, sb, ps;
        {we, wm, rm, br, pcw, irw, iord, sa, rd, mtr, ill} = '0;
        al = 2'b00; sb = 2'b00; ps = 2'b00;
        case (s)
            1:  begin rm = 1; sb = 2'b01; pcw = rdy; irw = rdy; end
            2:  sb = 2'b11;
            3, 10: begin sa = 1; sb = 2'b10; end
            4:  begin rm = 1; iord = 1; end
            5:  begin we = 1; mtr = 1; end
            6:  begin wm = 1; iord = 1; end
            7:  begin sa = 1; al = 2'b10; end
            8:  begin we = 1; rd = 1; end
            9:  begin sa = 1; al = 2'b01; br = 1; ps = 2'b01; end
            11: we = 1;
            12: begin pcw = 1; ps = 2'b10; end
            13: ill = 1;
            default: ;
        endcase
        return {we, wm, rm, br, al, pcw, irw, iord, sa, sb, ps, rd, mtr, ill};
    endfunction

    task automatic model_reset(input int i);
        cur[i] = 0; cnt[i] = 0; nsteps[i] = 0; pos[i] = 0;
    endtask

    // Post-decode step list for an opcode
    task automatic plan(input int i, input logic [5:0] op);
        nsteps[i] = 1;
        if (op == OP_LW || op == OP_SW) steps[i][0] = 3;
        else if (op == OP_R) begin steps[i][0] = 7; steps[i][1] = 8; nsteps[i] = 2; end
        else if (op == OP_BEQ) steps[i][0] = 9;
        else if (op == OP_J) steps[i][0] = 12;
        else if (op == OP_ADDI && aen[i]) begin steps[i][0] = 10; steps[i][1] = 11; nsteps[i] = 2; end
        else steps[i][0] = 13;
        pos[i] = 0;
    endtask

    task automatic model_step(input int i);
        bit rdy;
        rdy = !hs[i] || mem_ready;
        case (cur[i])
            0: cur[i] = 1;
            1: if (rdy) cur[i] = 2;
            2: begin plan(i, opcode); cur[i] = steps[i][0]; end
            13: ;
            default: begin
                if ((cur[i] == 4 || cur[i] == 6) && !rdy) begin
                    // waiting on memory
                end else begin
                    if (cur[i] == 3) begin
                        if (opcode == OP_LW) begin
                            steps[i][1] = 4; steps[i][2] = 5; nsteps[i] = 3;
                        end else begin
                            steps[i][1] = 6; nsteps[i] = 2;
                        end
                    end
                    pos[i]++;
                    if (pos[i] < nsteps[i]) cur[i] = steps[i][pos[i]];
                    else begin
                        cur[i] = 1;
                        cnt[i] = (cnt[i] + 1) % (1 << cw[i]);
                    end
                end
            end
        endcase
    endtask

    // ---------------- driver + per-cycle compare ----------------
    logic [16:0] s_outs[2];
    int s_state[2];
    int s_cnt[2];

    task automatic cycle(input logic [5:0] op, input logic rdy, input logic rst);
        @(negedge clk);
        opcode = op; mem_ready = rdy; rst_n = rst; zero = 1'($urandom_range(0, 1));
        if (!rst) begin model_reset(0); model_reset(1); end
        #1;
        s_outs[0] = a_outs; s_state[0] = int'(a_state); s_cnt[0] = int'(a_cnt);
        s_outs[1] = b_outs; s_state[1] = int'(b_state); s_cnt[1] = int'(b_cnt);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("state[%0d]", i), s_state[i], cur[i]);
            check($sformatf("outs[%0d]", i), int'(s_outs[i]),
                  int'(exp_outs(cur[i], !hs[i] || rdy)));
            check($sformatf("cnt[%0d]", i), s_cnt[i], cnt[i]);
        end
        @(posedge clk);
        if (rst) begin model_step(0); model_step(1); end
    endtask

    // ---------------- stimulus ----------------
    int r_exp[5]  = '{0, 1, 2, 7, 8};
    int lw_rdy[6] = '{1, 1, 0, 0, 1, 1};
    int lw_exp[6] = '{2, 3, 4, 4, 4, 5};
    logic [5:0] rop;

    initial begin
        rst_n = 1'b0; opcode = OP_R; mem_ready = 1'b1; zero = 1'b0;
        model_reset(0); model_reset(1);

        // reset
        cycle(OP_R, 1, 0);
        cycle(OP_R, 1, 0);
        check("reset_state", s_state[0], 0);
        check("reset_outs", int'(s_outs[0]), 0);
        check("reset_cnt", s_cnt[0], 0);

        // R-type, memory always ready: RST,FETCH,DECODE,REX,RWB
        for (int k = 0; k < 5; k++) begin
            cycle(OP_R, 1, 1);
            check("rtype_seq", s_state[0], r_exp[k]);
        end
        check("rtype_wb_outs", int'(s_outs[0]), int'(17'b1_0_0_0_00_0_0_0_0_00_00_1_0_0));
        cycle(OP_R, 1, 1);
        check("rtype_back_fetch", s_state[0], 1);
        check("rtype_retire", s_cnt[0], 1);

        // lw with two wait cycles in MEMRD (7 cycles incl. the FETCH above)
        for (int k = 0; k < 6; k++) begin
            cycle(OP_LW, 1'(lw_rdy[k]), 1);
            check("lw_seq", s_state[0], lw_exp[k]);
            if (lw_exp[k] == 4)
                check("lw_memrd_outs", int'(s_outs[0]), int'(17'b0_0_1_0_00_0_0_1_0_00_00_0_0_0));
        end
        check("lw_memwb_outs", int'(s_outs[0]), int'(17'b1_0_0_0_00_0_0_0_0_00_00_0_1_0));
        cycle(OP_LW, 1, 1);
        check("lw_back_fetch", s_state[0], 1);
        check("lw_retire", s_cnt[0], 2);

        // beq
        cycle(OP_BEQ, 1, 1);
        check("beq_decode", s_state[0], 2);
        cycle(OP_BEQ, 1, 1);
        check("beq_state", s_state[0], 9);
        check("beq_outs", int'(s_outs[0]), int'(17'b0_0_0_1_01_0_0_0_1_00_01_0_0_0));
        cycle(OP_BEQ, 1, 1);
        check("beq_back_fetch", s_state[0], 1);

        // illegal opcode traps and stays trapped
        cycle(6'b111111, 1, 1);
        check("trap_decode", s_state[0], 2);
        for (int k = 0; k < 20; k++) cycle(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1);
        check("trap_state", s_state[0], 13);
        check("trap_sticky", int'(s_outs[0][0]), 1);
        cycle(OP_R, 1, 0);
        check("trap_cleared", int'(s_outs[0][0]), 0);

        // addi: legal on inst 0, illegal on inst 1
        cycle(OP_ADDI, 1, 1);
        cycle(OP_ADDI, 1, 1);
        cycle(OP_ADDI, 1, 1);
        check("addi_decode", s_state[0], 2);
        cycle(OP_ADDI, 1, 1);
        check("addi_ex", s_state[0], 10);
        check("addi_b_trap", s_state[1], 13);
        cycle(OP_ADDI, 1, 1);
        check("addi_wb", s_state[0], 11);
        check("addi_wb_outs", int'(s_outs[0]), int'(17'b1_0_0_0_00_0_0_0_0_00_00_0_0_0));
        cycle(OP_ADDI, 1, 1);
        check("addi_retire", s_cnt[0], 1);
        check("addi_b_ill", int'(s_outs[1][0]), 1);

        // 16 jumps: 4-bit counter wraps to 0
        cycle(OP_J, 1, 0);
        cycle(OP_J, 1, 1);
        for (int k = 0; k < 48; k++) cycle(OP_J, 1, 1);
        check("jmp_a_cnt16", s_cnt[0], 15);
        cycle(OP_J, 1, 1);
        check("jmp_a_cnt", s_cnt[0], 16);
        check("jmp_b_wrap", s_cnt[1], 0);
        check("jmp_b_fetch", s_state[1], 1);

        // reset pulse in the middle of lw
        cycle(OP_LW, 1, 1);
        cycle(OP_LW, 1, 1);
        check("midlw_memadr", s_state[0], 3);
        cycle(OP_LW, 0, 1);
        check("midlw_memrd", s_state[0], 4);
        cycle(OP_LW, 0, 0);
        check("midlw_rst_state", s_state[0], 0);
        check("midlw_rst_outs", int'(s_outs[0]), 0);
        check("midlw_rst_cnt", s_cnt[0], 0);

        // randomized traffic against the model
        rop = OP_R;
        for (int k = 0; k < 3000; k++) begin
            int r;
            logic rs;
            if (cur[0] != 2 && cur[0] != 3 && cur[1] != 2 && cur[1] != 3) begin
                r = $urandom_range(0, 19);
                if (r < 4) rop = OP_R;
                else if (r < 7) rop = OP_LW;
                else if (r < 10) rop = OP_SW;
                else if (r < 13) rop = OP_BEQ;
                else if (r < 16) rop = OP_J;
                else if (r < 19) rop = OP_ADDI;
                else rop = 6'($urandom_range(0, 63));
            end
            if (cur[0] == 13 || cur[1] == 13) rs = ($urandom_range(0, 15) != 0);
            else rs = ($urandom_range(0, 299) != 0);
            cycle(rop, ($urandom_range(0, 3) != 0), rs);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Parametrised multicycle control unit for the MIPS datapath. It replaces hand-driven control stimulus with a Moore state machine that decodes the 6-bit opcode and sequences FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK. It drives `write_enable`, `write_memory`, `read_memory`, `branch` and `aluop`, plus the multicycle steering selects. It adds a memory-ready handshake, optional `addi` support, illegal-opcode trapping and a retired-instruction counter.

## Interface
- `CNT_W`, 16, width of `retired_cnt`.
- `MEM_HANDSHAKE`, 1. When 1, memory states wait for `mem_ready`. When 0, `mem_ready` is ignored and treated as 1.
- `ADDI_EN`, 1. When 0, opcode 001000 is illegal.

Ports (polarity and synchronicity of the reset are fixed):
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `opcode`  in  6  instruction register bits [31:26].
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory access completes this cycle.
- `write_enable`  out  1  register file write.
- `write_memory`  out  1  data memory write.
- `read_memory`  out  1  memory read.
- `branch`  out  1  conditional PC write (beq).
- `aluop`  out  2  00 add, 01 sub, 10 funct-decoded.
- `pc_write`  out  1  unconditional PC write.
- `ir_write`  out  1  instruction register load.
- `iord`  out  1  0 selects PC as memory address, 1 selects ALUOut.
- `alu_src_a`  out  1  0 selects PC, 1 selects register A.
- `alu_src_b`  out  2  00 selects B, 01 selects 4, 10 selects sign-ext imm, 11 selects sign-ext imm<<2.
- `pc_src`  out  2  00 selects ALU result, 01 selects ALUOut, 10 selects jump target.
- `reg_dst`  out  1  1 selects rd.
- `mem_to_reg`  out  1  1 selects MDR.
- `state`  out  4  current state encoding, for debug.
- `illegal_op`  out  1  sticky trap flag.
- `retired_cnt`  out  CNT_W  count of completed instructions.

## Operation
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- States and encodings:
  - RST=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, REX=7, RWB=8, BEQ=9, ADDIEX=10, ADDIWB=11, JMP=12, TRAP=13.
- Transitions:
  - RST goes to FETCH.
  - FETCH goes to DECODE when the access is ready; otherwise it holds.
  - DECODE dispatches by opcode:
    - lw or sw goes to MEMADR.
    - R-type goes to REX.
    - beq goes to BEQ.
    - j goes to JMP.
    - addi goes to ADDIEX when `ADDI_EN`=1.
    - Any other opcode goes to TRAP.
  - MEMADR goes to MEMRD for lw and to MEMWR for sw.
  - MEMRD goes to MEMWB when ready; otherwise it holds.
  - MEMWR goes to FETCH when ready; otherwise it holds.
  - REX goes to RWB.
  - ADDIEX goes to ADDIWB.
  - MEMWB, RWB, ADDIWB, BEQ and JMP go to FETCH.
  - TRAP holds until reset.
- "Ready" means `mem_ready`=1, or `MEM_HANDSHAKE`=0.
- Outputs not listed for a state are 0.
  - FETCH: `read_memory`=1, `alu_src_b`=01, `aluop`=00. `ir_write` and `pc_write` are asserted only in the ready cycle.
  - DECODE: `alu_src_b`=11, `aluop`=00.
  - MEMADR and ADDIEX: `alu_src_a`=1, `alu_src_b`=10, `aluop`=00.
  - MEMRD: `read_memory`=1, `iord`=1.
  - MEMWB: `write_enable`=1, `mem_to_reg`=1.
  - MEMWR: `write_memory`=1, `iord`=1.
  - REX: `alu_src_a`=1, `aluop`=10.
  - RWB: `write_enable`=1, `reg_dst`=1.
  - ADDIWB: `write_enable`=1.
  - BEQ: `alu_src_a`=1, `aluop`=01, `branch`=1, `pc_src`=01.
  - JMP: `pc_write`=1, `pc_src`=10.
  - TRAP: `illegal_op`=1.
- `opcode` is sampled only in DECODE and MEMADR. It is a don't-care elsewhere.
- `zero` is passed through to the datapath's PC-write logic via `branch`. The controller never consumes `zero` internally.
- `retired_cnt` increments by 1 on the final cycle of each instruction, i.e. the cycle that transitions into FETCH. It wraps modulo 2^CNT_W.

## Timing
- Asynchronous reset clears `state` to RST and `retired_cnt` to 0. All outputs are 0 during reset and in the RST cycle. The first FETCH occurs on the first clock edge after `rst_n` deasserts.
- Outputs are combinational from `state`. `ir_write` and `pc_write` in FETCH also depend on `mem_ready`. There is no registered output delay.
- Minimum latencies in cycles, with zero wait states:
  - lw 5.
  - sw, R-type and addi 4.
  - beq and j 3.
- Each low `mem_ready` cycle in FETCH, MEMRD or MEMWR adds exactly one cycle. Outputs are held stable while waiting.
- Reset asserted mid-instruction aborts it immediately. The counter does not increment for the aborted instruction.
- Counter wrap and instruction retire in the same cycle yield 0.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants;
  - the state encoding;
  - the `aluop` codes;
  - the mux-select codes for `alu_src_b` and `pc_src`.
- Single module. The retire counter is inline; no sub-module.

## Test plan
- R-type (000000), `mem_ready`=1 constantly: states 1,2,7,8,1. `write_enable`=1 with `reg_dst`=1 in cycle 4. `retired_cnt` goes 0 to 1.
- lw (100011) with `mem_ready`=0 for 2 cycles in MEMRD: lw takes 7 cycles. `read_memory`=1 and `iord`=1 are held through the waits. `mem_to_reg`=1 in MEMWB.
- beq (000100): BEQ state shows `branch`=1, `aluop`=01, `pc_src`=01. Returns to FETCH after 3 cycles.
- Opcode 111111, or 001000 with `ADDI_EN`=0: TRAP after DECODE. `illegal_op`=1 stays set for 20 cycles. Only `rst_n`=0 clears it.
- With `CNT_W`=4, run 16 j instructions: `retired_cnt` wraps to 0. A `rst_n` pulse mid-lw returns to RST with all outputs 0.
